fdd_head_tracker: RTL and testbench
===================================

// Module: fdd_head_tracker
// PURPOSE
//  Tracks emulated head position for the four emulated floppy units. Sits
//  downstream of the bus-steering stage: consumes its gated sel/step/dir/side
//  outputs, keeps a per-unit track counter, drives the per-unit track-0 lines
//  back into it, and posts settled-position events to the microcontroller via
//  a req/ack handshake so firmware can load the matching MFM track.
// PARAMETERS
//  MAX_TRACK      79     highest cylinder; counter saturates here (7-bit)
//  SETTLE_CYCLES  48000  xclk cycles of step/side quiet before an event posts
//  SETTLE_W       16     settle counter width; SETTLE_CYCLES < 2**SETTLE_W
// PORTS
//  xclk       in   1  system clock; all state on rising edge
//  rst        in   1  asynchronous, active-high reset
//  sel_n      in   4  gated unit selects, active low (bit i = unit i)
//  step_n     in   1  gated step, active low; head moves on rising edge
//  dir_n      in   1  gated direction: 1 = outward (toward 0), 0 = inward
//  side_n     in   1  gated side: 1 = lower head (side 0), 0 = side 1
//  trk0_n     out  4  per-unit track-0 indicator, low when track[i]==0
//  trk_req    out  1  event pending; fields below stable while high
//  trk_drive  out  2  unit number of presented event
//  trk_num    out  7  cylinder of presented event
//  trk_side   out  1  side of presented event (1 = side 1)
//  trk_ack    in   1  firmware ack, level, already synchronous to xclk
// BEHAVIOUR
//  - sel_n/step_n/dir_n/side_n: 2-FF synchronisers, reset to 1 (inactive);
//    all decisions use 2nd stage; step edge = 2nd stage 0 -> 1 vs its delayed copy.
//  - Active unit: lowest i with synced sel_n[i]==0; none -> step/side ignored.
//  - Step edge with active unit u: dir_n==1 -> track[u] = max(track[u]-1,0);
//    dir_n==0 -> track[u] = min(track[u]+1,MAX_TRACK). dir sampled same cycle.
//    Saturated step still counts as a step (restarts settle).
//  - Synced side_n change while unit u active also restarts settle[u];
//    side[u] latched from synced side_n every cycle unit u is active.
//  - settle[u]: loaded SETTLE_CYCLES-1 on step/side event, decrements to 0;
//    on 1->0 transition sets pending[u]. Re-trigger while counting reloads.
//    Idle counter (0, not armed) never sets pending.
//  - Event FSM, 2 states:
//    IDLE: if pending!=0, pick lowest set bit p; latch trk_drive=p,
//      trk_num=track[p], trk_side=side[p]; clear pending[p]; -> PRESENT,
//      trk_req=1 next cycle.
//    PRESENT: hold all fields; when trk_ack==1 -> IDLE, trk_req=0 next cycle.
//    At least one IDLE cycle between events; ack in IDLE ignored.
//  - pending[p] set in the same cycle it is cleared by IDLE latch: set wins.
//  - New steps on presented unit during PRESENT do not alter latched fields;
//    they re-pend after settle and are reported as a later event.
//  - trk0_n[i] combinational from registered track[i] (no extra latency).
//  - Reset (any time, incl. mid-PRESENT or mid-settle): track[*]=0, side[*]=0,
//    settle[*]=0 disarmed, pending=0, FSM=IDLE, trk_req=0, trk_drive=0,
//    trk_num=0, trk_side=0, trk0_n=4'b0000, synchronisers=1.
//  - Latency: step rising edge at pins -> track update 3 xclk later;
//    -> trk_req high SETTLE_CYCLES+4 xclk later (no contention).
// TESTING
//  1 reset, sel_n=4'b1110, dir_n=0, 3 step pulses -> track0=3, trk0_n[0]=1,
//    one event {drive 0, trk 3, side 0} after settle; ack -> req low.
//  2 unit 0 at 0, dir_n=1, step -> track stays 0, trk0_n[0]=0, event posted.
//  3 unit 2 at 79, dir_n=0, step -> stays 79; sel_n=4'b1111 step -> no change,
//    no event.
//  4 units 0 and 2 stepped same cycle window, both expire before ack ->
//    event drive 0 first, then drive 2 after ack + 1 IDLE cycle.
//  5 hold trk_ack=0 while unit 0 stepped again -> latched fields unchanged;
//    after ack, second event with new track.
//  6 assert rst mid-PRESENT with settle armed -> all outputs reset values
//    same cycle, no event after rst release.

Source files
------------

// File: rtl/fdd_head_tracker.sv
// Emulated floppy head position tracker for four units. Synchronises the
// gated drive-bus controls, keeps a saturating cylinder counter per unit,
// drives per-unit track-0 lines and posts settled-position events to the
// microcontroller over a level req/ack handshake.
module fdd_head_tracker #(
    parameter int unsigned MAX_TRACK     = 79,
    parameter int unsigned SETTLE_CYCLES = 48000,
    parameter int unsigned SETTLE_W      = 16
) (
    input  logic       xclk,
    input  logic       rst,
    input  logic [3:0] sel_n,
    input  logic       step_n,
    input  logic       dir_n,
    input  logic       side_n,
    output logic [3:0] trk0_n,
    output logic       trk_req,
    output logic [1:0] trk_drive,
    output logic [6:0] trk_num,
    output logic       trk_side,
    input  logic       trk_ack
);

    localparam logic [6:0]          MaxTrk     = 7'(MAX_TRACK);
    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    // Synchroniser stages and delayed copies for edge/change detection
    logic [3:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [2:0] ctl_s1_q, ctl_s1_d, ctl_s2_q, ctl_s2_d;  // {side, dir, step}
    logic       step_dly_q, step_dly_d, side_dly_q, side_dly_d;

    // Per-unit state
    logic [3:0][6:0]          track_q, track_d;
    logic [3:0][SETTLE_W-1:0] settle_q, settle_d;
    logic [3:0]               armed_q, armed_d;
    logic [3:0]               side_q, side_d;
    logic [3:0]               pending_q, pending_d;

    // Event FSM and its registered outputs
    state_e     state_q;
    logic       trk_req_q;
    logic [1:0] trk_drive_q;
    logic [6:0] trk_num_q;
    logic       trk_side_q;

    logic       step_s, dir_s, side_s;
    logic       act_valid;
    logic [1:0] act_unit;
    logic       step_evt, side_evt;
    logic [3:0] pend_set, pend_clr;
    logic       pick_valid;
    logic [1:0] pick_unit;

    assign step_s = ctl_s2_q[0];
    assign dir_s  = ctl_s2_q[1];
    assign side_s = ctl_s2_q[2];

    // Next-state for synchronisers, track counters, settle timers and pending set
    always_comb begin
        sel_s1_d   = sel_n;
        sel_s2_d   = sel_s1_q;
        ctl_s1_d   = {side_n, dir_n, step_n};
        ctl_s2_d   = ctl_s1_q;
        step_dly_d = step_s;
        side_dly_d = side_s;

        act_valid = 1'b0;
        act_unit  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!sel_s2_q[i]) begin
                act_valid = 1'b1;
                act_unit  = 2'(i);
            end
        end

        step_evt = act_valid && step_s && !step_dly_q;
        side_evt = act_valid && (side_s != side_dly_q);

        track_d  = track_q;
        settle_d = settle_q;
        armed_d  = armed_q;
        side_d   = side_q;
        pend_set = 4'b0000;

        // Armed timer that has reached zero posts exactly one event
        for (int i = 0; i < 4; i++) begin
            if (settle_q[i] != '0) begin
                settle_d[i] = settle_q[i] - 1'b1;
            end else if (armed_q[i]) begin
                pend_set[i] = 1'b1;
                armed_d[i]  = 1'b0;
            end
        end

        if (act_valid) begin
            side_d[act_unit] = ~side_s;
            if (step_evt) begin
                if (dir_s) begin
                    if (track_q[act_unit] != 7'd0) begin
                        track_d[act_unit] = track_q[act_unit] - 7'd1;
                    end
                end else if (track_q[act_unit] < MaxTrk) begin
                    track_d[act_unit] = track_q[act_unit] + 7'd1;
                end
            end
            // A new step or side change restarts the quiet period
            if (step_evt || side_evt) begin
                settle_d[act_unit] = SettleLoad;
                armed_d[act_unit]  = 1'b1;
                pend_set[act_unit] = 1'b0;
            end
        end
    end

    // Lowest pending unit is taken when the FSM is idle; a same-cycle set wins
    always_comb begin
        pick_valid = (state_q == StIdle) && (pending_q != 4'b0000);
        pick_unit  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_unit = 2'(i);
            end
        end
        pend_clr = 4'b0000;
        if (pick_valid) begin
            pend_clr[pick_unit] = 1'b1;
        end
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    // Datapath state registers
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            sel_s1_q   <= 4'b1111;
            sel_s2_q   <= 4'b1111;
            ctl_s1_q   <= 3'b111;
            ctl_s2_q   <= 3'b111;
            step_dly_q <= 1'b1;
            side_dly_q <= 1'b1;
            track_q    <= '0;
            settle_q   <= '0;
            armed_q    <= 4'b0000;
            side_q     <= 4'b0000;
            pending_q  <= 4'b0000;
        end else begin
            sel_s1_q   <= sel_s1_d;
            sel_s2_q   <= sel_s2_d;
            ctl_s1_q   <= ctl_s1_d;
            ctl_s2_q   <= ctl_s2_d;
            step_dly_q <= step_dly_d;
            side_dly_q <= side_dly_d;
            track_q    <= track_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            side_q     <= side_d;
            pending_q  <= pending_d;
        end
    end

    // Event FSM: latch one pending unit, hold it until firmware acks
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            trk_req_q   <= 1'b0;
            trk_drive_q <= 2'd0;
            trk_num_q   <= 7'd0;
            trk_side_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        trk_drive_q <= pick_unit;
                        trk_num_q   <= track_q[pick_unit];
                        trk_side_q  <= side_q[pick_unit];
                        trk_req_q   <= 1'b1;
                        state_q     <= StPresent;
                    end
                end
                StPresent: begin
                    if (trk_ack) begin
                        trk_req_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Track-0 lines follow the registered counters directly
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            trk0_n[i] = (track_q[i] != 7'd0);
        end
    end

    assign trk_req   = trk_req_q;
    assign trk_drive = trk_drive_q;
    assign trk_num   = trk_num_q;
    assign trk_side  = trk_side_q;

endmodule

// File: tb/tb_fdd_head_tracker.sv
// Directed bench for fdd_head_tracker with a shortened settle time.
module tb_fdd_head_tracker;

    localparam int unsigned SC = 20;

    logic       xclk;
    logic       rst;
    logic [3:0] sel_n;
    logic       step_n;
    logic       dir_n;
    logic       side_n;
    logic [3:0] trk0_n;
    logic       trk_req;
    logic [1:0] trk_drive;
    logic [6:0] trk_num;
    logic       trk_side;
    logic       trk_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    fdd_head_tracker #(
        .MAX_TRACK    (79),
        .SETTLE_CYCLES(SC),
        .SETTLE_W     (8)
    ) dut (
        .xclk     (xclk),
        .rst      (rst),
        .sel_n    (sel_n),
        .step_n   (step_n),
        .dir_n    (dir_n),
        .side_n   (side_n),
        .trk0_n   (trk0_n),
        .trk_req  (trk_req),
        .trk_drive(trk_drive),
        .trk_num  (trk_num),
        .trk_side (trk_side),
        .trk_ack  (trk_ack)
    );

    initial xclk = 1'b0;
    always #5 xclk = ~xclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge xclk);
    endtask

    // Low pulse on step_n; returns at the negedge where step_n rises
    task automatic pulse();
        step_n = 1'b0;
        tick(2);
        step_n = 1'b1;
    endtask

    // Count negedges until trk_req rises, bounded
    task automatic wait_req(input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge xclk);
            n = i;
            if (trk_req) break;
        end
        chk(tag, {31'd0, trk_req}, 32'd1);
    endtask

    task automatic ack();
        trk_ack = 1'b1;
        tick(1);
        trk_ack = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        sel_n   = 4'b1111;
        step_n  = 1'b1;
        dir_n   = 1'b1;
        side_n  = 1'b1;
        trk_ack = 1'b0;
        tick(2);
        chk("rst_req", {31'd0, trk_req}, 32'd0);
        chk("rst_drive", {30'd0, trk_drive}, 32'd0);
        chk("rst_num", {25'd0, trk_num}, 32'd0);
        chk("rst_side", {31'd0, trk_side}, 32'd0);
        chk("rst_trk0", {28'd0, trk0_n}, 32'h0);
        rst = 1'b0;

        // 1: three inward steps on unit 0
        sel_n = 4'b1110;
        dir_n = 1'b0;
        tick(3);
        pulse();
        tick(2);
        chk("t1_trk0_early", {28'd0, trk0_n}, 32'h0);
        tick(1);
        chk("t1_trk0_lat3", {28'd0, trk0_n}, 32'h1);
        tick(2);
        pulse();
        tick(5);
        pulse();
        wait_req("t1_req", cyc);
        chk("t1_latency", cyc, SC + 4);
        chk("t1_drive", {30'd0, trk_drive}, 32'd0);
        chk("t1_num", {25'd0, trk_num}, 32'd3);
        chk("t1_side", {31'd0, trk_side}, 32'd0);
        ack();
        chk("t1_req_drop", {31'd0, trk_req}, 32'd0);
        tick(40);
        chk("t1_no_more", {31'd0, trk_req}, 32'd0);

        // 2: step outward to 0 and once more at 0
        dir_n = 1'b1;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            pulse();
            tick(5);
        end
        wait_req("t2_req", cyc);
        chk("t2_num", {25'd0, trk_num}, 32'd0);
        chk("t2_drive", {30'd0, trk_drive}, 32'd0);
        chk("t2_trk0", {28'd0, trk0_n}, 32'h0);
        ack();

        // 3: unit 2 to the outer limit, saturating step, then deselected step
        sel_n = 4'b1011;
        dir_n = 1'b0;
        tick(3);
        for (int i = 0; i < 80; i++) begin
            pulse();
            tick(3);
        end
        wait_req("t3_req", cyc);
        chk("t3_drive", {30'd0, trk_drive}, 32'd2);
        chk("t3_num", {25'd0, trk_num}, 32'd79);
        chk("t3_trk0", {28'd0, trk0_n}, 32'h4);
        ack();
        tick(2);
        pulse();
        wait_req("t3_sat_req", cyc);
        chk("t3_sat_num", {25'd0, trk_num}, 32'd79);
        ack();
        sel_n = 4'b1111;
        tick(3);
        pulse();
        tick(60);
        chk("t3_nosel_req", {31'd0, trk_req}, 32'd0);
        chk("t3_nosel_trk0", {28'd0, trk0_n}, 32'h4);

        // 4: units 0 and 2 both pending, lowest first
        sel_n = 4'b1110;
        tick(3);
        pulse();
        tick(3);
        sel_n = 4'b1011;
        dir_n = 1'b1;
        tick(3);
        pulse();
        wait_req("t4_req0", cyc);
        chk("t4_drive0", {30'd0, trk_drive}, 32'd0);
        chk("t4_num0", {25'd0, trk_num}, 32'd1);
        tick(40);
        chk("t4_hold_drive", {30'd0, trk_drive}, 32'd0);
        chk("t4_trk0", {28'd0, trk0_n}, 32'h5);
        ack();
        chk("t4_idle_gap", {31'd0, trk_req}, 32'd0);
        tick(1);
        chk("t4_req2", {31'd0, trk_req}, 32'd1);
        chk("t4_drive2", {30'd0, trk_drive}, 32'd2);
        chk("t4_num2", {25'd0, trk_num}, 32'd78);
        ack();

        // 5: new step and side change during PRESENT leave latched fields alone
        sel_n = 4'b1110;
        dir_n = 1'b0;
        tick(3);
        pulse();
        wait_req("t5_req", cyc);
        chk("t5_num", {25'd0, trk_num}, 32'd2);
        pulse();
        tick(5);
        side_n = 1'b0;
        tick(40);
        chk("t5_hold_req", {31'd0, trk_req}, 32'd1);
        chk("t5_hold_num", {25'd0, trk_num}, 32'd2);
        chk("t5_hold_side", {31'd0, trk_side}, 32'd0);
        ack();
        tick(1);
        chk("t5_req2", {31'd0, trk_req}, 32'd1);
        chk("t5_num2", {25'd0, trk_num}, 32'd3);
        chk("t5_side2", {31'd0, trk_side}, 32'd1);
        ack();

        // 6: reset while presenting with a settle timer armed
        tick(2);
        pulse();
        wait_req("t6_req", cyc);
        chk("t6_num", {25'd0, trk_num}, 32'd4);
        pulse();
        tick(5);
        #2;
        rst    = 1'b1;
        sel_n  = 4'b1111;
        side_n = 1'b1;
        #1;
        chk("t6_rst_req", {31'd0, trk_req}, 32'd0);
        chk("t6_rst_drive", {30'd0, trk_drive}, 32'd0);
        chk("t6_rst_num", {25'd0, trk_num}, 32'd0);
        chk("t6_rst_side", {31'd0, trk_side}, 32'd0);
        chk("t6_rst_trk0", {28'd0, trk0_n}, 32'h0);
        tick(3);
        rst = 1'b0;
        tick(60);
        chk("t6_post_req", {31'd0, trk_req}, 32'd0);
        chk("t6_post_trk0", {28'd0, trk0_n}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
